// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_div_unit: iterative radix-2 multiply/divide unit, signed and unsigned  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int         c_cw   = $clog2(WIDTH);
  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;
  localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [c_cw-1:0]  r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_rem;
  logic             r_dz;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;

  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum, w_shift, w_diff;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_q_s, w_r_s;

  // Signed ops are op[0]==0; magnitudes of the most-negative value fit unsigned
  assign w_a_neg = ~op[0] & a[WIDTH-1];
  assign w_b_neg = ~op[0] & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  // {r_rem, r_quo} is a 2*WIDTH+1 bit accumulator shared by both algorithms
  assign w_mul_sum = r_rem + {1'b0, (r_quo[0] ? r_opb : {WIDTH{1'b0}})};
  assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opb};

  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    if (r_is_div) begin
      if (w_shift >= {1'b0, r_opb}) begin
        w_rem_nx = w_diff;
        w_quo_nx = {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        w_rem_nx = w_shift;
        w_quo_nx = {r_quo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_rem_nx = {1'b0, w_mul_sum[WIDTH:1]};
      w_quo_nx = {w_mul_sum[0], r_quo[WIDTH-1:1]};
    end
  end

  assign w_prod   = {w_rem_nx[WIDTH-1:0], w_quo_nx};
  assign w_prod_s = r_neg_res ? (~w_prod + 1'b1) : w_prod;
  assign w_q_s    = r_neg_res ? (~w_quo_nx + 1'b1) : w_quo_nx;
  assign w_r_s    = r_neg_rem ? (~w_rem_nx[WIDTH-1:0] + 1'b1) : w_rem_nx[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dz      <= 1'b0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      hi        <= '0;
      lo        <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start && !flush) begin
            r_state   <= c_busy;
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dz      <= op[1] & (b == '0);
            r_opb     <= op[1] ? w_b_mag : w_a_mag;
            r_quo     <= op[1] ? w_a_mag : w_b_mag;
            r_rem     <= '0;
          end
        end
        c_busy: begin
          if (flush) begin
            r_state <= c_idle;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
              r_state <= c_done;
              if (!r_is_div) begin
                {hi, lo} <= w_prod_s;
                div_zero <= 1'b0;
              end else begin
                // Zero divisor leaves |a| in the remainder, so hi re-signs to a
                hi       <= w_r_s;
                lo       <= r_dz ? {WIDTH{1'b1}} : w_q_s;
                div_zero <= r_dz;
              end
            end
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy = (r_state != c_idle);
  assign done = (r_state == c_done);

endmodule
`default_nettype wire
